// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM states, bridge read
// types and address field widths.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        MISS   = 2'd2,
        REFILL = 2'd3
    } state_t;

    localparam logic [2:0] RD_TYPE_WORD = 3'b010;
    localparam logic [2:0] RD_TYPE_LINE = 3'b100;

    localparam int TAG_W      = 20;
    localparam int INDEX_W    = 8;
    localparam int OFFSET_W   = 4;
    localparam int LINE_WORDS = 4;
    localparam int SETS       = 256;

endpackage

// File: rtl/icache_tagv_ram.sv
// Tag/valid store: 256 x {valid, tag}. Valid bits clear asynchronously on
// reset; tags are plain registers. One write port, combinational read.
module icache_tagv_ram
    import icache_pkg::*;
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               we,
    input  logic [INDEX_W-1:0] waddr,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [INDEX_W-1:0] raddr,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag
);

    logic [SETS-1:0] vld;
    logic [TAG_W-1:0] tag_mem [SETS];

    // valid bits: cleared on reset, set when a line finishes refilling
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) vld <= '0;
        else if (we) vld[waddr] <= 1'b1;
    end

    // tag storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (we) tag_mem[waddr] <= wtag;
    end

    assign rvalid = vld[raddr];
    assign rtag   = tag_mem[raddr];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped 4 KB instruction cache (256 sets x 16-byte lines) between
// the fetch stage and the AXI bridge. Misses refill a full line; uncached
// requests fetch a single word and never touch the arrays.
// Optional macro ICACHE_PERF_CNT_EN adds hit_cnt / miss_cnt outputs.
module inst_cache
    import icache_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        uncache,
    input  logic [19:0] tag,
    input  logic [7:0]  index,
    input  logic [3:0]  offset,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    state_t state, state_n;

    logic               req_unc;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [1:0]         req_word;
    logic [1:0]         cnt;
    logic [31:0]        hold;
    logic               hit;
    logic               tv_valid;
    logic [TAG_W-1:0]   tv_tag;
    logic               line_done;
    logic               unused_byte_sel;

    logic [31:0] data_arr [SETS][LINE_WORDS];

    // byte lane within a word is irrelevant for instruction fetch
    assign unused_byte_sel = ^offset[1:0];

    assign hit       = (state == LOOKUP) && !req_unc && tv_valid && (tv_tag == req_tag);
    assign line_done = (state == REFILL) && ret_valid && ret_last && !req_unc;

    icache_tagv_ram u_tagv (
        .clk    (clk),
        .resetn (resetn),
        .we     (line_done),
        .waddr  (req_idx),
        .wtag   (req_tag),
        .raddr  (req_idx),
        .rvalid (tv_valid),
        .rtag   (tv_tag)
    );

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_n;
    end

    // latch the request only at the handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_unc  <= 1'b0;
            req_tag  <= '0;
            req_idx  <= '0;
            req_word <= '0;
        end else if (valid && addr_ok) begin
            req_unc  <= uncache;
            req_tag  <= tag;
            req_idx  <= index;
            req_word <= offset[3:2];
        end
    end

    // refill word counter and critical-word holding register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt  <= '0;
            hold <= '0;
        end else if (state == MISS && rd_rdy) begin
            cnt <= '0;
        end else if (state == REFILL && ret_valid) begin
            cnt <= cnt + 2'd1;
            if (req_unc || cnt == req_word) hold <= ret_data;
        end
    end

    // line data written beat by beat during a cached refill
    always_ff @(posedge clk) begin
        if (state == REFILL && ret_valid && !req_unc) data_arr[req_idx][cnt] <= ret_data;
    end

    // next state and all handshake outputs
    always_comb begin
        state_n = state;
        addr_ok = 1'b0;
        data_ok = 1'b0;
        rdata   = '0;
        rd_req  = 1'b0;
        rd_type = '0;
        rd_addr = '0;
        case (state)
            IDLE: begin
                addr_ok = valid;
                if (valid) state_n = LOOKUP;
            end
            LOOKUP: begin
                if (hit) begin
                    data_ok = 1'b1;
                    rdata   = data_arr[req_idx][req_word];
                    addr_ok = valid;
                    state_n = valid ? LOOKUP : IDLE;
                end else begin
                    state_n = MISS;
                end
            end
            MISS: begin
                rd_req  = 1'b1;
                rd_type = req_unc ? RD_TYPE_WORD : RD_TYPE_LINE;
                rd_addr = req_unc ? {req_tag, req_idx, req_word, 2'b00}
                                  : {req_tag, req_idx, 4'b0000};
                if (rd_rdy) state_n = REFILL;
            end
            REFILL: begin
                if (ret_valid && ret_last) begin
                    data_ok = 1'b1;
                    // the last beat may itself be the wanted word
                    rdata   = (req_unc || cnt == req_word) ? ret_data : hold;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef ICACHE_PERF_CNT_EN
    // lookup outcome counters; every LOOKUP either hits or goes to MISS
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (hit) hit_cnt  <= hit_cnt + 32'd1;
            else     miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: a requester issues directed and random
// fetches, a reference cache model predicts hit/miss and data, a bridge
// model serves reads from a hashed memory, and a monitor checks data_ok.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0, uncache = 1'b0;
    logic [19:0] tag = '0;
    logic [7:0]  index = '0;
    logic [3:0]  offset = '0;
    logic        addr_ok, data_ok, rd_req;
    logic [31:0] rdata, rd_addr;
    logic [2:0]  rd_type;
    logic        rd_rdy = 1'b0, ret_valid = 1'b0, ret_last = 1'b0;
    logic [31:0] ret_data = '0;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    inst_cache dut (
        .clk(clk), .resetn(resetn), .valid(valid), .uncache(uncache),
        .tag(tag), .index(index), .offset(offset),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data)
`ifdef ICACHE_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
    );

    typedef struct { logic [31:0] data; bit hit; int cyc; } exp_t;
    typedef struct { logic [31:0] addr; logic [2:0] typ; } breq_t;

    exp_t        exp_q[$];
    breq_t       breq_q[$];
    bit          mv[256];
    logic [19:0] mt[256];
    int          checks = 0, errors = 0;
    int          cycle = 0;
    bit          stall = 0;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] mem(logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h0badf00d;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    // reference cache: direct-mapped, allocate on cached miss only
    function automatic void accept(bit unc, logic [31:0] a);
        exp_t  e;
        breq_t b;
        logic [7:0]  idx = a[11:4];
        logic [19:0] tg  = a[31:12];
        e.hit  = !unc && mv[idx] && mt[idx] == tg;
        e.data = mem(a & ~32'h3);
        e.cyc  = cycle + 1;
        exp_q.push_back(e);
        if (!e.hit) begin
            b.addr = unc ? (a & ~32'h3) : (a & ~32'hf);
            b.typ  = unc ? 3'b010 : 3'b100;
            breq_q.push_back(b);
            if (!unc) begin
                mv[idx] = 1'b1;
                mt[idx] = tg;
            end
        end
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [19:0] tg;
        logic [7:0]  idx;
        logic [3:0]  off;
        case ($urandom_range(0, 2))
            0: tg = 20'h1fc00;
            1: tg = 20'h00000;
            default: tg = 20'h1fc01;
        endcase
        idx = 8'($urandom_range(0, 3));
        off = 4'($urandom_range(0, 15));
        return {tg, idx, off};
    endfunction

    task automatic drive(bit unc, logic [31:0] a);
        valid   = 1'b1;
        uncache = unc;
        tag     = a[31:12];
        index   = a[11:4];
        offset  = a[3:0];
    endtask

    // present one request and hold it until accepted
    task automatic req(bit unc, logic [31:0] a, bit now);
        int n = 0;
        @(negedge clk);
        drive(unc, a);
        #1;
        while (!addr_ok && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!addr_ok) fail("req_accept");
        else begin
            if (now) check("addr_ok_b2b_wait", n, 0);
            accept(unc, a);
        end
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    // requester keeps changing its address while the cache is busy
    task automatic wander();
        int n = 0;
        bit got = 0;
        logic [31:0] a;
        while (!got && n < 500) begin
            @(negedge clk);
            a = rand_addr();
            drive(1'b0, a);
            #1;
            if (addr_ok) begin
                check("addr_ok_while_busy", exp_q.size(), 0);
                accept(1'b0, a);
                got = 1;
            end else n++;
        end
        if (!got) fail("wander_accept");
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    // monitor: every data_ok pops one expected response
    exp_t mon_e;
    always @(negedge clk) begin
        if (resetn && data_ok) begin
            if (exp_q.size() == 0) fail("spurious_data_ok");
            else begin
                mon_e = exp_q.pop_front();
                check("rdata", rdata, mon_e.data);
                checks++;
                if (mon_e.hit ? (cycle != mon_e.cyc) : (cycle <= mon_e.cyc + 1)) begin
                    errors++;
                    $display("FAIL latency actual_cycle=%0d expected=%0d hit=%0d", cycle, mon_e.cyc, mon_e.hit);
                end
            end
        end
    end

    // bridge model: random grant delay and return gaps
    initial begin : bridge
        breq_t       b;
        int          nw;
        logic [31:0] base;
        bit          aborted;
        forever begin
            @(posedge clk);
            #1;
            if (resetn && rd_req && $urandom_range(0, 2) != 0) begin
                if (breq_q.size() == 0) fail("unexpected_rd_req");
                else begin
                    b = breq_q.pop_front();
                    check("rd_addr", rd_addr, b.addr);
                    check("rd_type", 32'(rd_type), 32'(b.typ));
                end
                nw   = (rd_type == 3'b100) ? 4 : 1;
                base = rd_addr;
                rd_rdy = 1'b1;
                @(posedge clk);
                #1;
                rd_rdy  = 1'b0;
                aborted = 0;
                for (int i = 0; i < nw && !aborted; i++) begin
                    while (resetn && (stall || $urandom_range(0, 3) == 0)) begin
                        @(posedge clk);
                        #1;
                    end
                    if (!resetn) aborted = 1;
                    else begin
                        ret_valid = 1'b1;
                        ret_last  = (i == nw - 1);
                        ret_data  = mem(base + 32'(4 * i));
                        @(posedge clk);
                        #1;
                        ret_valid = 1'b0;
                        ret_last  = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check_idle_outputs(string pfx);
        check({pfx, "_addr_ok"}, 32'(addr_ok), 0);
        check({pfx, "_data_ok"}, 32'(data_ok), 0);
        check({pfx, "_rdata"},   rdata, 0);
        check({pfx, "_rd_req"},  32'(rd_req), 0);
        check({pfx, "_rd_type"}, 32'(rd_type), 0);
        check({pfx, "_rd_addr"}, rd_addr, 0);
    endtask

    initial begin : main
        int n;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        resetn = 1'b1;

        // cold miss, then hit on the same line
        req(1'b0, 32'h1fc00004, 1'b0);
        req(1'b0, 32'h1fc0000c, 1'b0);
        // back-to-back hit stream
        for (int i = 0; i < 4; i++) req(1'b0, 32'h1fc00000 + 32'(4 * i), i != 0);
        // uncached reads; the cached follow-up to a fresh line must miss
        req(1'b1, 32'h1fc00008, 1'b0);
        req(1'b1, 32'h1fc00018, 1'b0);
        req(1'b0, 32'h1fc00018, 1'b0);
        // conflict on index 0
        req(1'b0, 32'h00000000, 1'b0);
        req(1'b0, 32'h1fc00000, 1'b0);
        // changing address while busy
        req(1'b0, 32'h1fc01020, 1'b0);
        wander();

        // random traffic
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            req($urandom_range(0, 7) == 0, rand_addr(), 1'b0);
            if ($urandom_range(0, 9) == 0) wander();
        end

        // reset in the middle of a refill
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        stall = 1;
        req(1'b0, 32'h1fc02040, 1'b0);
        n = 0;
        while (breq_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (breq_q.size() != 0) fail("refill_grant");
        repeat (2) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_idle_outputs("midreset");
`ifdef ICACHE_PERF_CNT_EN
        check("hit_cnt_reset", hit_cnt, 0);
        check("miss_cnt_reset", miss_cnt, 0);
`endif
        for (int i = 0; i < 256; i++) mv[i] = 1'b0;
        exp_q.delete();
        breq_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        stall  = 0;
        req(1'b0, 32'h1fc02040, 1'b0);
        req(1'b0, 32'h1fc02044, 1'b0);
        req(1'b0, 32'h1fc00004, 1'b0);

        n = 0;
        while ((exp_q.size() != 0 || breq_q.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_exp", exp_q.size(), 0);
        check("drain_breq", breq_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_cache.md
Name: inst_cache

Overview:
- Responder end of the fetch-stage instruction-cache request interface: accepts valid/uncache/tag/index/offset requests and answers with addr_ok, data_ok and rdata.
- Direct-mapped, 256 sets, 16-byte lines (20-bit tag, 8-bit index, 4-bit offset), 4 KB total.
- On a miss, or for an uncached access, it issues a read to the AXI bridge through a simple rd_req / ret_valid interface.
- Sits between the fetch stage and the AXI bridge.

Parameters:
- LINE_WORDS, 4, words per line; fixed by the 4-bit offset.
- SETS, 256, number of sets; fixed by the 8-bit index.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- valid  in  1  request valid
- uncache  in  1  1 = uncached single-word read
- tag  in  20  physical tag
- index  in  8  set index
- offset  in  4  byte offset within the line; bits [1:0] are ignored
- addr_ok  out  1  request accepted this cycle
- data_ok  out  1  rdata valid this cycle
- rdata  out  32  instruction word
- rd_req  out  1  bridge read request
- rd_type  out  3  3'b100 = 16-byte line, 3'b010 = single word
- rd_addr  out  32  line-aligned address {tag,index,4'b0}, or the exact word address when uncached
- rd_rdy  in  1  bridge accepts rd_req
- ret_valid  in  1  return word valid
- ret_last  in  1  last return word
- ret_data  in  32  return word

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; all 256 valid bits=0.
  - addr_ok=0, data_ok=0, rdata=0, rd_req=0.
  - rd_type and rd_addr are 0.
  - Reset mid-refill abandons the line; the bridge is reset in the same domain.
- Request register: latches {uncache,tag,index,offset} on valid&addr_ok. Inputs are sampled only at the handshake. The requester may change its address while addr_ok=0.
- Every accepted request produces exactly one data_ok. Requests are never cancelled; the requester discards unwanted data itself.
- States:
  - IDLE: addr_ok=valid. On handshake -> LOOKUP.
  - LOOKUP:
    - Hit when !uncache_r && valid[index_r] && tag_arr[index_r]==tag_r.
    - On hit: data_ok=1 this cycle, rdata=data_arr[index_r][offset_r[3:2]].
    - On hit, addr_ok=valid in the same cycle. If a new request is accepted, stay in LOOKUP; else -> IDLE.
    - On miss or uncache: data_ok=0, addr_ok=0 -> MISS.
  - MISS:
    - rd_req=1. rd_type=3'b010 if uncache_r, else 3'b100.
    - rd_addr={tag_r,index_r,offset_r[3:2],2'b00} if uncache_r, else {tag_r,index_r,4'b0}.
    - On rd_rdy -> REFILL, with word counter=0.
  - REFILL:
    - On each ret_valid, the counter increments (2 bits, wraps).
    - If cached: write data_arr[index_r][cnt]=ret_data. The word with cnt==offset_r[3:2] is captured into a holding register. If uncached, ret_data is captured directly.
    - On ret_valid&ret_last:
      - If cached, set valid[index_r]=1 and tag_arr[index_r]=tag_r.
      - Assert data_ok=1 that cycle, with rdata = the captured word. If the last word is itself the critical word, rdata = ret_data.
      - Then -> IDLE.
- addr_ok=0 in MISS and REFILL.
- Latency: hit = 1 cycle after the handshake. A back-to-back hit stream gives one word per cycle.
- Uncached accesses never allocate or modify the arrays.
- Arrays are register-based with combinational read, indexed by the registered index.

Optional Feature:
- Macro ICACHE_PERF_CNT_EN.
- When defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0], both reset to 0.
  - hit_cnt increments on every LOOKUP hit.
  - miss_cnt increments on every LOOKUP->MISS transition, cached or uncached.
  - Both wrap at 2^32.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package icache_pkg:
  - State encodings IDLE/LOOKUP/MISS/REFILL.
  - RD_TYPE_WORD=3'b010 and RD_TYPE_LINE=3'b100.
  - TAG_W=20, INDEX_W=8, OFFSET_W=4.
- Sub-module icache_tagv_ram: 256 × {valid, tag}, async clear of the valid bits, one write port, combinational read.

Test Plan:
- Cold miss, addr 0x1fc00004, cached:
  - rd_req with rd_addr=0x1fc00000, rd_type=4.
  - Return 0x11,0x22,0x33,0x44 -> data_ok in the ret_last cycle with rdata=0x22.
  - Re-request 0x1fc0000c -> data_ok 1 cycle later, rdata=0x44, no rd_req.
- Back-to-back hits on 0x1fc00000..0x1fc0000c with valid held high:
  - addr_ok=1 every cycle after the first.
  - data_ok on 4 consecutive cycles, in order.
- Uncached 0x1fc00008:
  - rd_type=2, rd_addr=0x1fc00008, one return 0xdead -> data_ok with rdata=0xdead.
  - A later cached request to the same line still misses.
- Conflict: fill index 0x00 with tag 0x1fc00, then request tag 0x00000 at index 0x00 -> miss and refill. The old tag then misses again.
- While in REFILL, valid=1 with a changing address:
  - addr_ok stays 0 until IDLE.
  - The first request presented in IDLE is the one latched.
- resetn pulsed low during REFILL:
  - Outputs immediately 0, state IDLE.
  - A re-request of the same line misses.
  - With ICACHE_PERF_CNT_EN, both counters read 0.
